// File: rtl/uart_rx_deserializer_if.sv
// Line-side and Rx-FIFO-side signals of the 16x oversampling UART receiver.
// The slave modport belongs to the receiver. The master modport belongs to whatever drives the line and observes the outputs.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_rx;
  logic                  i_rxff_full;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_rx_done;
  logic                  o_frame_error;
  logic                  o_overrun;
  logic                  o_busy;

  modport master (
    output i_rx,
    output i_rxff_full,
    input  o_data,
    input  o_rx_done,
    input  o_frame_error,
    input  o_overrun,
    input  o_busy
  );

  modport slave (
    input  i_rx,
    input  i_rxff_full,
    output o_data,
    output o_rx_done,
    output o_frame_error,
    output o_overrun,
    output o_busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver that oversamples the line at 16x baud. It writes each good byte into the Rx FIFO
// with a one-clock strobe, and it flags framing errors and sticky overruns.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 326,
  parameter int STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  uart_rx_deserializer_if.slave bus
);

  localparam int DIV_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int S_MAX = (STOP_TICKS > 16) ? STOP_TICKS : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BAUD_DIV - 1);
  localparam logic [S_W-1:0]   S_MID      = S_W'(7);
  localparam logic [S_W-1:0]   S_BIT_END  = S_W'(15);
  localparam logic [S_W-1:0]   S_STOP_END = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0]   N_LAST     = N_W'(DATA_WIDTH - 1);

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr,
                                                      input logic                  b);
    shift_in = {b, sr[DATA_WIDTH-1:1]};
  endfunction

  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick;
  logic [1:0]            state_q, state_d;
  logic [S_W-1:0]        s_q, s_d;
  logic [N_W-1:0]        n_q, n_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  // Stage 0: two-flop synchronizer and free-running oversample divider
  always_comb begin
    rx_meta_d = bus.i_rx;
    rx_s_d    = rx_meta_q;
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
  end

  // Stage 1: frame FSM; the outputs are registered so that o_rx_done follows the stop sample by one clock
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    case (state_q)
      ST_IDLE: begin
        // A falling edge is acted on immediately, so the start-bit centre is measured from the edge itself
        if (!rx_s_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d = '0;
            if (!rx_s_q) begin
              state_d = ST_DATA;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_q == S_BIT_END) begin
            shreg_d = shift_in(shreg_q, rx_s_q);
            s_d     = '0;
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_q == S_STOP_END) begin
            // The FSM leaves at mid stop bit, so the next start edge can follow with no idle gap
            state_d = ST_IDLE;
            s_d     = '0;
            if (rx_s_q) begin
              data_d = shreg_q;
              done_d = 1'b1;
              if (bus.i_rxff_full) begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      div_q     <= div_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_rx_done     = done_q;
  assign bus.o_frame_error = ferr_q;
  assign bus.o_overrun     = ovr_q;
  assign bus.o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer at BAUD_DIV=2 (32 clocks per bit). It uses a table of directed frames,
// a random frame stream scored against a queue model, and hand sequences for break and mid-frame reset.
module tb_uart_rx_deserializer;
  localparam int DW  = 8;
  localparam int BD  = 2;
  localparam int STK = 16;
  localparam int BIT = BD * 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_deserializer #(
    .DATA_WIDTH(DW),
    .BAUD_DIV  (BD),
    .STOP_TICKS(STK)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Rx FIFO model (4 deep) and output monitor
  logic       ff_en    = 1'b0;
  logic       ff_force = 1'b0;
  int         ff_cnt   = 0;
  logic [7:0] ff_q[$];
  logic [7:0] got_q[$];
  int         n_done = 0;
  int         n_fe   = 0;
  int         viol   = 0;
  logic       prev_done = 1'b0;
  logic       prev_fe   = 1'b0;
  time        t_done  = 0;
  time        t_start = 0;

  assign bus.i_rxff_full = ff_force | (ff_en && ff_cnt >= 4);

  always @(negedge clk) begin
    if (bus.o_rx_done) begin
      n_done++;
      t_done = $time;
      got_q.push_back(bus.o_data);
      if (ff_en && ff_q.size() < 4) ff_q.push_back(bus.o_data);
    end
    if (bus.o_frame_error) n_fe++;
    if ((bus.o_rx_done && bus.o_frame_error) || (bus.o_rx_done && prev_done) ||
        (bus.o_frame_error && prev_fe))
      viol++;
    prev_done = bus.o_rx_done;
    prev_fe   = bus.o_frame_error;
    ff_cnt    = ff_q.size();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    bus.i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is held low only long enough to be sampled. The line is then released,
  // so the start re-detected after the frame error is rejected as a glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
    t_start = $time;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
    if (stop) begin
      drive_bit(1'b1, BIT);
    end else begin
      drive_bit(1'b0, 24);
      drive_bit(1'b1, BIT - 24);
    end
    if (gap_bits > 0) drive_bit(1'b1, gap_bits * BIT);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    logic       glitch_before;
    int         gap;
    int         exp_done;
    int         exp_fe;
    logic [7:0] exp_data;
    logic       exp_ov;
  } vec_t;

  vec_t       tbl[7];
  logic [7:0] exp_q[$];
  int         exp_fe;
  logic [7:0] rd;
  logic       rstop;
  int         rgap;

  initial begin
    // Frame, stop bit, FIFO-full, glitch before, gap bits, then the expected done and fe pulses, o_data and o_overrun
    tbl[0] = '{8'h81, 1'b1, 1'b0, 1'b0, 0, 1, 0, 8'h81, 1'b0};
    tbl[1] = '{8'h7E, 1'b1, 1'b0, 1'b0, 0, 1, 0, 8'h7E, 1'b0};
    tbl[2] = '{8'h08, 1'b1, 1'b0, 1'b0, 1, 1, 0, 8'h08, 1'b0};
    tbl[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1, 0, 1, 8'h08, 1'b0};
    tbl[4] = '{8'h55, 1'b1, 1'b0, 1'b1, 1, 1, 0, 8'h55, 1'b0};
    tbl[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1, 1, 0, 8'h3C, 1'b1};
    tbl[6] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1, 1, 0, 8'hC3, 1'b1};

    bus.i_rx = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", bus.o_data, 8'h00);
    chk("reset_done", bus.o_rx_done, 1'b0);
    chk("reset_fe", bus.o_frame_error, 1'b0);
    chk("reset_ovr", bus.o_overrun, 1'b0);
    chk("reset_busy", bus.o_busy, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    ff_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].glitch_before) begin
        n_done = 0;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        chk("glitch_done", n_done, 0);
        chk("glitch_busy", bus.o_busy, 1'b0);
      end
      n_done   = 0;
      n_fe     = 0;
      t_done   = 0;
      ff_force = tbl[i].full;
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap);
      ff_force = 1'b0;
      chk($sformatf("vec%0d_done", i), n_done, tbl[i].exp_done);
      chk($sformatf("vec%0d_fe", i), n_fe, tbl[i].exp_fe);
      chk($sformatf("vec%0d_data", i), bus.o_data, tbl[i].exp_data);
      chk($sformatf("vec%0d_ovr", i), bus.o_overrun, tbl[i].exp_ov);
      if (tbl[i].gap > 0) chk($sformatf("vec%0d_busy", i), bus.o_busy, 1'b0);
      if (tbl[i].exp_done > 0)
        chk_rng($sformatf("vec%0d_latency", i), int'((t_done - t_start) / 10), 300, 316);
      if (i == 2) begin
        chk("fifo_count", ff_q.size(), 3);
        if (ff_q.size() == 3) begin
          chk("fifo_0", ff_q[0], 8'h81);
          chk("fifo_1", ff_q[1], 8'h7E);
          chk("fifo_2", ff_q[2], 8'h08);
        end
        ff_en = 1'b0;
        ff_q.delete();
      end
    end

    // Random frame stream against a queue model
    got_q.delete();
    exp_q.delete();
    exp_fe = 0;
    n_fe   = 0;
    for (int k = 0; k < 24; k++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      rgap  = rstop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      if (rstop) exp_q.push_back(rd);
      else exp_fe++;
      send_frame(rd, rstop, rgap);
    end
    drive_bit(1'b1, 2 * BIT);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("rand_byte%0d", k), got_q[k], exp_q[k]);
    chk("rand_fe", n_fe, exp_fe);

    // Break: each frame time held low yields one frame error and never a done strobe
    n_done = 0;
    n_fe   = 0;
    drive_bit(1'b0, 1010);
    chk("break_fe", n_fe, 3);
    chk("break_done", n_done, 0);
    drive_bit(1'b1, 400);

    // Reset during data bit 4 clears the outputs asynchronously
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(i[0], BIT);
    drive_bit(1'b0, 16);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", bus.o_data, 8'h00);
    chk("midrst_done", bus.o_rx_done, 1'b0);
    chk("midrst_fe", bus.o_frame_error, 1'b0);
    chk("midrst_ovr", bus.o_overrun, 1'b0);
    chk("midrst_busy", bus.o_busy, 1'b0);
    bus.i_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (64) @(negedge clk);
    n_done = 0;
    n_fe   = 0;
    send_frame(8'hFF, 1'b1, 1);
    chk("postrst_done", n_done, 1);
    chk("postrst_data", bus.o_data, 8'hFF);
    chk("postrst_fe", n_fe, 0);
    chk("postrst_ovr", bus.o_overrun, 1'b0);

    chk("pulse_invariants", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
